// File: rtl/ldpc_uart_feeder.sv
// ldpc_uart_feeder: word FIFO between the LDPC encoder and a 16-bit UART
// transmitter that has no ready output. Each stored word leaves as a single
// uart_en pulse. A fixed dead time after every pulse is long enough for the
// two-byte frame plus a tail bit, so a new pulse never lands on a frame that
// is still being shifted out.
module ldpc_uart_feeder #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int UART_BPS = 115200,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [15:0]       in_data,
    output logic              in_ready,
    output logic              uart_en,
    output logic [15:0]       uart_din,
    output logic              busy,
    output logic [ADDR_W:0]   fifo_count,
    output logic [15:0]       words_sent
);

    localparam int BPS_CNT    = CLK_FREQ / UART_BPS;
    localparam int GAP_CYCLES = 21 * BPS_CNT;
    localparam int GAP_W      = $clog2(GAP_CYCLES + 1);

    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_ONE  = 1;
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_GAP  = 1'b1;

    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q,      count_d;
    logic [0:0]        state_q,      state_d;
    logic [GAP_W-1:0]  gap_q,        gap_d;
    logic              uart_en_q,    uart_en_d;
    logic [15:0]       uart_din_q,   uart_din_d;
    logic [15:0]       words_sent_q, words_sent_d;

    logic empty;
    logic full;
    logic push;
    logic pop;

    assign empty = (count_q == '0);
    // Full is taken from the registered count, so a full FIFO refuses a push
    // even on an edge where the FSM pops.
    assign full  = (count_q == FULL_CNT);
    assign push  = in_valid & ~full;
    assign pop   = (state_q == ST_IDLE) & ~empty;

    // Occupancy bookkeeping: a push and a pop on the same edge cancel out.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Sender FSM: issue one word per pulse, then sit out the inter-word gap.
    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        uart_en_d    = 1'b0;
        uart_din_d   = uart_din_q;
        words_sent_d = words_sent_q;
        case (state_q)
            ST_IDLE: begin
                // uart_din is only ever loaded from an occupied slot.
                if (!empty) begin
                    uart_din_d   = mem[rd_ptr_q];
                    uart_en_d    = 1'b1;
                    words_sent_d = words_sent_q + 16'd1;
                    gap_d        = GAP_LOAD;
                    state_d      = ST_GAP;
                end
            end
            default: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_ONE;
                end
            end
        endcase
    end

    // Control and output registers; reset discards queued words immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= ST_IDLE;
            gap_q        <= '0;
            uart_en_q    <= 1'b0;
            uart_din_q   <= '0;
            words_sent_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q      <= count_d;
            state_q      <= state_d;
            gap_q        <= gap_d;
            uart_en_q    <= uart_en_d;
            uart_din_q   <= uart_din_d;
            words_sent_q <= words_sent_d;
        end
    end

    // Word storage written on accepted pushes.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; the count guards every read, so stale slots are never observed.
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    assign in_ready   = ~full;
    assign busy       = (state_q != ST_IDLE) | ~empty;
    assign fifo_count = count_q;
    assign uart_en    = uart_en_q;
    assign uart_din   = uart_din_q;
    assign words_sent = words_sent_q;

endmodule

// File: tb/tb_ldpc_uart_feeder.sv
// Bench for ldpc_uart_feeder. The reference model keeps the accepted words in
// order and predicts each pulse edge as max(accept+1, previous pulse+GAP+1);
// occupancy and busy follow from those edge lists. A transmitter model shifts
// each pulsed word onto a serial line and a decoder rebuilds the words.
module tb_ldpc_uart_feeder;

    localparam int CLK_FREQ = 1_000_000;
    localparam int UART_BPS = 100_000;
    localparam int DEPTH    = 16;
    localparam int ADDR_W   = 4;
    localparam int BPS      = CLK_FREQ / UART_BPS;
    localparam int GAP      = 21 * BPS;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              in_valid = 1'b0;
    logic [15:0]       in_data  = '0;
    logic              in_ready;
    logic              uart_en;
    logic [15:0]       uart_din;
    logic              busy;
    logic [ADDR_W:0]   fifo_count;
    logic [15:0]       words_sent;

    ldpc_uart_feeder #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .uart_en    (uart_en),
        .uart_din   (uart_din),
        .busy       (busy),
        .fifo_count (fifo_count),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int peak     = 0;

    // Reference model: accept edges, predicted pulse edges, words in order.
    int          acc_e[$];
    int          pls_e[$];
    logic [15:0] acc_w[$];
    int          n_seen   = 0;
    int          act_pls[$];
    logic [15:0] ws_model = '0;
    logic [15:0] last_din = '0;

    // Transmitter model and serial decoder.
    logic [19:0] tx_shift = '1;
    int          tx_left  = 0;
    int          tx_tick  = 0;
    logic        tx_line  = 1'b1;
    int          rx_p     = 0;
    logic [7:0]  rx_byte  = '0;
    logic [7:0]  rx_bytes[$];
    logic [15:0] tx_exp[$];
    int          rx_words = 0;

    function automatic int model_count(input int t);
        int c;
        c = 0;
        foreach (acc_e[i]) if (acc_e[i] <= t) c++;
        foreach (pls_e[i]) if (pls_e[i] <= t) c--;
        return c;
    endfunction

    function automatic bit model_busy(input int t);
        bit b;
        b = (model_count(t) > 0);
        foreach (pls_e[i]) if (pls_e[i] <= t && t < pls_e[i] + GAP) b = 1'b1;
        return b;
    endfunction

    task automatic model_clear();
        acc_e.delete();
        pls_e.delete();
        acc_w.delete();
        n_seen   = 0;
        ws_model = '0;
        last_din = '0;
    endtask

    task automatic decode_line();
        int          idx;
        logic [15:0] word;
        logic [15:0] exp_w;
        if (rx_p == 0) begin
            if (tx_line == 1'b0) rx_p = 1;
        end else begin
            rx_p++;
            if (rx_p > BPS / 2 && ((rx_p - BPS / 2) % BPS) == 0) begin
                idx = (rx_p - BPS / 2) / BPS;
                if (idx <= 8) begin
                    rx_byte[idx-1] = tx_line;
                end else begin
                    checks++;
                    assert (tx_line === 1'b1) else begin
                        failures++; $error("FAIL stop_bit: got %b expected 1", tx_line);
                    end
                    rx_bytes.push_back(rx_byte);
                    rx_p = 0;
                    if (rx_bytes.size() == 2) begin
                        word = {rx_bytes[1], rx_bytes[0]};
                        rx_bytes.delete();
                        rx_words++;
                        checks++;
                        assert (tx_exp.size() > 0) else begin
                            failures++; $error("FAIL serial_extra: got word %h expected none", word);
                        end
                        if (tx_exp.size() > 0) begin
                            exp_w = tx_exp.pop_front();
                            checks++;
                            assert (word === exp_w) else begin
                                failures++; $error("FAIL serial_word: got %h expected %h", word, exp_w);
                            end
                        end
                    end
                end
            end
        end
    endtask

    // One clock: wait for the falling edge, then observe pulses and run the line models.
    task automatic tick();
        bit start;
        @(negedge clk);
        cyc++;
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
        decode_line();
        start = 1'b0;
        if (uart_en === 1'b1) begin
            start = 1'b1;
            checks++;
            assert (n_seen < acc_w.size()) else begin
                failures++; $error("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
            end
            if (n_seen < acc_w.size()) begin
                checks++;
                assert (cyc == pls_e[n_seen]) else begin
                    failures++; $error("FAIL pulse_time: got cycle %0d expected %0d", cyc, pls_e[n_seen]);
                end
                checks++;
                assert (uart_din === acc_w[n_seen]) else begin
                    failures++; $error("FAIL pulse_data: got %h expected %h", uart_din, acc_w[n_seen]);
                end
                ws_model = ws_model + 16'd1;
                checks++;
                assert (words_sent === ws_model) else begin
                    failures++; $error("FAIL words_sent: got %h expected %h", words_sent, ws_model);
                end
                last_din = acc_w[n_seen];
                tx_exp.push_back(acc_w[n_seen]);
                n_seen++;
            end
            act_pls.push_back(cyc);
            checks++;
            assert (tx_left == 0) else begin
                failures++; $error("FAIL frame_overlap: got %0d bits pending expected 0", tx_left);
            end
        end else begin
            checks++;
            assert (uart_en === 1'b0 && uart_din === last_din) else begin
                failures++; $error("FAIL din_hold: got en=%b din=%h expected en=0 din=%h", uart_en, uart_din, last_din);
            end
        end
        if (start) begin
            tx_shift = {1'b1, uart_din[15:8], 1'b0, 1'b1, uart_din[7:0], 1'b0};
            tx_left  = 20;
            tx_tick  = 0;
        end else if (tx_left > 0) begin
            tx_tick++;
            if (tx_tick == BPS) begin
                tx_tick  = 0;
                tx_shift = tx_shift >> 1;
                tx_left--;
            end
        end
        tx_line = (tx_left > 0) ? tx_shift[0] : 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        int c;
        c = model_count(cyc);
        checks++;
        assert (fifo_count === (ADDR_W + 1)'(c)) else begin
            failures++; $error("FAIL %s_count: got %0d expected %0d at cycle %0d", tag, fifo_count, c, cyc);
        end
        checks++;
        assert (in_ready === ((c < DEPTH) ? 1'b1 : 1'b0)) else begin
            failures++; $error("FAIL %s_ready: got %b expected %b at cycle %0d", tag, in_ready, (c < DEPTH), cyc);
        end
        checks++;
        assert (busy === model_busy(cyc)) else begin
            failures++; $error("FAIL %s_busy: got %b expected %b at cycle %0d", tag, busy, model_busy(cyc), cyc);
        end
    endtask

    task automatic check_reset(input string tag);
        checks++;
        assert (uart_en === 1'b0 && uart_din === 16'h0000) else begin
            failures++; $error("FAIL %s_uart: got en=%b din=%h expected en=0 din=0000", tag, uart_en, uart_din);
        end
        checks++;
        assert (fifo_count === '0 && words_sent === 16'h0000) else begin
            failures++; $error("FAIL %s_counts: got cnt=%0d sent=%0d expected 0 0", tag, fifo_count, words_sent);
        end
        checks++;
        assert (busy === 1'b0 && in_ready === 1'b1) else begin
            failures++; $error("FAIL %s_flags: got busy=%b ready=%b expected 0 1", tag, busy, in_ready);
        end
    endtask

    task automatic step(input string tag);
        tick();
        check_outputs(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Offer one word and hold it until accepted; leaves in_valid low afterwards.
    task automatic push(input logic [15:0] w);
        int waited;
        int last;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (in_ready !== 1'b1 && waited < 1000) begin
            step("hold");
            waited++;
        end
        checks++;
        assert (waited < 1000) else begin
            failures++; $error("FAIL push_timeout: got %0d cycles expected under 1000", waited);
        end
        if (waited >= 1000) begin
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        last = (pls_e.size() > 0) ? pls_e[pls_e.size()-1] : -100000;
        acc_e.push_back(cyc);
        acc_w.push_back(w);
        pls_e.push_back((cyc + 1 > last + GAP + 1) ? cyc + 1 : last + GAP + 1);
        check_outputs("push");
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while ((n_seen < acc_w.size() || model_busy(cyc)) && guard < 8000) begin
            step(tag);
            guard++;
        end
        checks++;
        assert (n_seen == acc_w.size()) else begin
            failures++; $error("FAIL %s_drain: got %0d pulses expected %0d", tag, n_seen, acc_w.size());
        end
    endtask

    initial begin
        int base;
        int e;
        int target;

        // Reset state, then a quiet idle stretch.
        rst = 1'b1;
        repeat (3) tick();
        check_reset("reset");
        rst = 1'b0;
        run(50, "idle");
        checks++;
        assert (act_pls.size() == 0) else begin
            failures++; $error("FAIL idle_pulses: got %0d expected 0", act_pls.size());
        end

        // Single word: pulse one cycle after the push edge, busy clears 211 cycles later.
        push(16'hA55A);
        e = acc_e[acc_e.size()-1];
        drain("single");
        checks++;
        assert (act_pls.size() == 1 && act_pls[0] == e + 1) else begin
            failures++; $error("FAIL single_edge: got %0d pulses expected one at %0d", act_pls.size(), e + 1);
        end
        checks++;
        assert (words_sent === 16'd1 && busy === 1'b0) else begin
            failures++; $error("FAIL single_done: got sent=%0d busy=%b expected 1 0", words_sent, busy);
        end

        // Three back-to-back words: exact spacing and an occupancy peak of 2.
        base = act_pls.size();
        peak = 0;
        push(16'h0001);
        push(16'h0002);
        push(16'h0003);
        drain("burst3");
        checks++;
        assert (peak == 2) else begin
            failures++; $error("FAIL burst3_peak: got %0d expected 2", peak);
        end
        checks++;
        assert (act_pls.size() == base + 3) else begin
            failures++; $error("FAIL burst3_pulses: got %0d expected %0d", act_pls.size(), base + 3);
        end
        if (act_pls.size() == base + 3) begin
            checks++;
            assert (act_pls[base+1] - act_pls[base] == GAP + 1 && act_pls[base+2] - act_pls[base+1] == GAP + 1) else begin
                failures++; $error("FAIL burst3_spacing: got %0d,%0d expected %0d", act_pls[base+1] - act_pls[base], act_pls[base+2] - act_pls[base+1], GAP + 1);
            end
        end

        // Fill to DEPTH while the FSM sits in its gap; the 17th word waits for space.
        push(16'($urandom));
        run(5, "lead");
        for (int i = 0; i < DEPTH; i++) push(16'($urandom));
        checks++;
        assert (fifo_count === (ADDR_W + 1)'(DEPTH) && in_ready === 1'b0) else begin
            failures++; $error("FAIL full: got cnt=%0d ready=%b expected %0d 0", fifo_count, in_ready, DEPTH);
        end
        push(16'($urandom));
        drain("fill");

        // Reset 100 cycles after a pulse with five words still queued.
        push(16'($urandom));
        target = pls_e[pls_e.size()-1] + 100;
        for (int i = 0; i < 5; i++) push(16'($urandom));
        while (cyc < target) step("pre_rst");
        rst = 1'b1;
        #1;
        check_reset("rst_mid");
        model_clear();
        tick();
        rst = 1'b0;
        check_outputs("after_rst");
        base = act_pls.size();
        run(500, "post_rst");
        checks++;
        assert (act_pls.size() == base) else begin
            failures++; $error("FAIL post_rst_pulses: got %0d expected %0d", act_pls.size(), base);
        end

        // Counter wrap: preload 0xFFFF, the next pulse brings it to 0.
        force dut.words_sent_q = 16'hFFFF;
        tick();
        release dut.words_sent_q;
        ws_model = 16'hFFFF;
        step("preload");
        checks++;
        assert (words_sent === 16'hFFFF) else begin
            failures++; $error("FAIL preload: got %h expected ffff", words_sent);
        end
        push(16'($urandom));
        drain("wrap");
        checks++;
        assert (words_sent === 16'h0000) else begin
            failures++; $error("FAIL wrap: got %h expected 0000", words_sent);
        end

        // Random arrivals with random idle gaps.
        for (int i = 0; i < 8; i++) begin
            run(int'($urandom_range(0, 250)), "rand_idle");
            push(16'($urandom));
        end
        drain("random");

        // Let the last frame finish on the line, then confirm every word decoded.
        run(300, "tail");
        checks++;
        assert (tx_exp.size() == 0 && rx_bytes.size() == 0 && rx_words > 0) else begin
            failures++; $error("FAIL serial_drain: got %0d words undecoded expected 0", tx_exp.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
